// File: rtl/bsr_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : bsr_pkg
//  Description : Shared types and constants for the BSR block path: the
//                scheduler state encoding, the per-block descriptor, the
//                weight-block geometry and the weight byte-base helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package bsr_pkg;

  // Address width of the row_ptr/col_idx BRAMs.
  localparam int BSR_ADDR_W = 10;

  // Weight block geometry: 14x14 INT8 padded to 25 beats of 8 bytes.
  localparam int BLK_BEATS  = 25;
  localparam int BEAT_BYTES = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD_P0  = 3'd1,
    S_RD_PN  = 3'd2,
    S_RD_COL = 3'd3,
    S_EMIT   = 3'd4,
    S_DONE   = 3'd5
  } sched_state_t;

  typedef struct packed {
    logic [15:0]           row;
    logic [15:0]           col;
    logic [BSR_ADDR_W-1:0] blk;
    logic [BSR_ADDR_W+6:0] wgt_base;
    logic                  last;
  } desc_t;

  // k*200 built from shifts (128+64+8); result wraps at the weight address width.
  function automatic logic [BSR_ADDR_W+6:0] wgt_base_200(input logic [BSR_ADDR_W-1:0] k);
    logic [BSR_ADDR_W+6:0] t7;
    logic [BSR_ADDR_W+6:0] t6;
    logic [BSR_ADDR_W+6:0] t3;
    t7 = {k, 7'b0};
    t6 = {1'b0, k, 6'b0};
    t3 = {4'b0, k, 3'b0};
    return t7 + t6 + t3;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bsr_desc_skid.sv
`default_nettype none
// ============================================================================
//  Module      : bsr_desc_skid
//  Description : Two-entry skid buffer for the descriptor stream. The
//                upstream ready depends only on the local fill count, so
//                the consumer's ready never feeds back into the scheduler
//                combinationally. Entries are held stable while stalled.
//  Revision    : 1.0 - initial release
// ============================================================================
module bsr_desc_skid #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o
);

  logic [DATA_W-1:0] mem_q [2];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        cnt_q;
  logic [1:0]        cnt_d;
  logic              w_push;
  logic              w_pop;

  assign in_ready_o  = (cnt_q != 2'd2);
  assign out_valid_o = (cnt_q != 2'd0);
  assign out_data_o  = mem_q[rd_ptr_q];
  assign w_push      = in_valid_i && in_ready_o;
  assign w_pop       = out_valid_o && out_ready_i;

  // Fill count follows push/pop; simultaneous push and pop leaves it unchanged.
  always_comb begin
    cnt_d = cnt_q;
    case ({w_push, w_pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage, pointers and count; everything clears on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (w_push) begin
        mem_q[wr_ptr_q] <= in_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (w_pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bsr_block_sched.sv
`default_nettype none
// ============================================================================
//  Module      : bsr_block_sched
//  Description : Walks the BSR row_ptr/col_idx BRAMs and emits one
//                descriptor (row, column, block index, weight byte base,
//                last flag) per non-zero block through a 2-entry skid.
//                Optional build macro BSR_SCHED_CHECK_EN enables row_ptr
//                monotonicity and column range checking with sticky error.
//  Revision    : 1.0 - initial release
// ============================================================================
module bsr_block_sched
  import bsr_pkg::*;
#(
  parameter int BRAM_ADDR_W = bsr_pkg::BSR_ADDR_W,  // must equal BSR_ADDR_W (descriptor field widths)
  parameter int BLK_BEATS   = bsr_pkg::BLK_BEATS,
  parameter int BEAT_BYTES  = bsr_pkg::BEAT_BYTES
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic [31:0]            csr_num_rows_i,
  input  logic [31:0]            csr_num_cols_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   error_o,
  output logic                   row_ptr_re_o,
  output logic [BRAM_ADDR_W-1:0] row_ptr_raddr_o,
  input  logic [31:0]            row_ptr_rdata_i,
  output logic                   col_idx_re_o,
  output logic [BRAM_ADDR_W-1:0] col_idx_raddr_o,
  input  logic [15:0]            col_idx_rdata_i,
  output logic                   desc_valid_o,
  input  logic                   desc_ready_i,
  output logic [15:0]            desc_row_o,
  output logic [15:0]            desc_col_o,
  output logic [BRAM_ADDR_W-1:0] desc_blk_o,
  output logic [BRAM_ADDR_W+6:0] desc_wgt_base_o,
  output logic                   desc_last_o
);

  localparam int BLK_BYTES = BLK_BEATS * BEAT_BYTES;

  sched_state_t state_q, state_d;
  logic [1:0]   phase_q, phase_d;     // BRAM wait sub-cycle inside RD_P0/RD_PN
  logic [31:0]  r_q, r_d;             // current block row
  logic [31:0]  k_q, k_d;             // current block index
  logic [31:0]  kend_q, kend_d;       // row_ptr[r+1]
  logic [31:0]  nnz_q, nnz_d;         // row_ptr[num_rows]: total block count
  logic [31:0]  nrows_q, nrows_d;
  logic [15:0]  col_q, col_d;         // col_idx held across skid stalls
  logic         col_fresh_q, col_fresh_d;
  logic         error_q, error_d;
  logic         busy_q, busy_d;

  logic         w_push;
  logic         w_skid_ready;
  logic [15:0]  w_col;
  logic [31:0]  w_r_inc;
  logic [31:0]  w_k_inc;
  logic         w_more_rows;
  logic         w_row_bad;
  logic         w_col_bad;
  logic [BRAM_ADDR_W+6:0] w_wgt;
  desc_t        w_desc;
  desc_t        w_out;

  // The col_idx word is on the BRAM output only in the first EMIT cycle.
  assign w_col       = col_fresh_q ? col_idx_rdata_i : col_q;
  assign w_r_inc     = r_q + 32'd1;
  assign w_k_inc     = k_q + 32'd1;
  assign w_more_rows = (w_r_inc < nrows_q);

`ifdef BSR_SCHED_CHECK_EN
  logic [31:0] ncols_q, ncols_d;
  assign w_row_bad = (row_ptr_rdata_i < k_q);
  assign w_col_bad = ({16'b0, w_col} >= ncols_q);
`else
  logic unused_cols;
  assign unused_cols = ^csr_num_cols_i;
  assign w_row_bad   = 1'b0;
  assign w_col_bad   = 1'b0;
`endif

  // Default geometry uses the shift form; other geometries fall back to a multiply.
  assign w_wgt = (BLK_BYTES == 200) ? wgt_base_200(k_q[BRAM_ADDR_W-1:0])
                                    : ({7'b0, k_q[BRAM_ADDR_W-1:0]} * BLK_BYTES[BRAM_ADDR_W+6:0]);

  // Descriptor for the block currently in EMIT.
  always_comb begin
    w_desc          = '0;
    w_desc.row      = r_q[15:0];
    w_desc.col      = w_col;
    w_desc.blk      = k_q[BRAM_ADDR_W-1:0];
    w_desc.wgt_base = w_wgt;
    // Last is the final block overall, so trailing empty rows do not hide it.
    w_desc.last     = (w_k_inc == kend_q) && (kend_q == nnz_q);
  end

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      phase_q     <= 2'd0;
      r_q         <= '0;
      k_q         <= '0;
      kend_q      <= '0;
      nnz_q       <= '0;
      nrows_q     <= '0;
      col_q       <= '0;
      col_fresh_q <= 1'b0;
      error_q     <= 1'b0;
      busy_q      <= 1'b0;
`ifdef BSR_SCHED_CHECK_EN
      ncols_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      r_q         <= r_d;
      k_q         <= k_d;
      kend_q      <= kend_d;
      nnz_q       <= nnz_d;
      nrows_q     <= nrows_d;
      col_q       <= col_d;
      col_fresh_q <= col_fresh_d;
      error_q     <= error_d;
      busy_q      <= busy_d;
`ifdef BSR_SCHED_CHECK_EN
      ncols_q     <= ncols_d;
`endif
    end
  end

  // Next-state, BRAM read and descriptor push decode.
  always_comb begin
    state_d         = state_q;
    phase_d         = phase_q;
    r_d             = r_q;
    k_d             = k_q;
    kend_d          = kend_q;
    nnz_d           = nnz_q;
    nrows_d         = nrows_q;
    col_d           = col_q;
    col_fresh_d     = 1'b0;
    error_d         = error_q;
    busy_d          = busy_q;
`ifdef BSR_SCHED_CHECK_EN
    ncols_d         = ncols_q;
`endif
    row_ptr_re_o    = 1'b0;
    row_ptr_raddr_o = '0;
    col_idx_re_o    = 1'b0;
    col_idx_raddr_o = '0;
    w_push          = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          nrows_d = csr_num_rows_i;
`ifdef BSR_SCHED_CHECK_EN
          ncols_d = csr_num_cols_i;
`endif
          r_d     = '0;
          phase_d = 2'd0;
          error_d = 1'b0;
          busy_d  = 1'b1;
          state_d = (csr_num_rows_i == 32'd0) ? S_DONE : S_RD_P0;
        end
      end

      // Fetch row_ptr[0] (start block) then row_ptr[num_rows] (block count).
      S_RD_P0: begin
        case (phase_q)
          2'd0: begin
            row_ptr_re_o = 1'b1;
            phase_d      = 2'd1;
          end
          2'd1: begin
            k_d             = row_ptr_rdata_i;
            row_ptr_re_o    = 1'b1;
            row_ptr_raddr_o = nrows_q[BRAM_ADDR_W-1:0];
            phase_d         = 2'd2;
          end
          default: begin
            nnz_d   = row_ptr_rdata_i;
            phase_d = 2'd0;
            state_d = S_RD_PN;
          end
        endcase
      end

      S_RD_PN: begin
        if (phase_q == 2'd0) begin
          row_ptr_re_o    = 1'b1;
          row_ptr_raddr_o = w_r_inc[BRAM_ADDR_W-1:0];
          phase_d         = 2'd1;
        end else begin
          kend_d  = row_ptr_rdata_i;
          phase_d = 2'd0;
          if (row_ptr_rdata_i > k_q) begin
            state_d = S_RD_COL;
          end else if (w_row_bad) begin
            error_d = 1'b1;
            state_d = S_DONE;
          end else begin
            r_d     = w_r_inc;
            state_d = w_more_rows ? S_RD_PN : S_DONE;
          end
        end
      end

      S_RD_COL: begin
        col_idx_re_o    = 1'b1;
        col_idx_raddr_o = k_q[BRAM_ADDR_W-1:0];
        col_fresh_d     = 1'b1;
        state_d         = S_EMIT;
      end

      S_EMIT: begin
        col_d = w_col;
        if (w_col_bad) begin
          error_d = 1'b1;
          state_d = S_DONE;
        end else begin
          w_push = 1'b1;
          if (w_skid_ready) begin
            k_d = w_k_inc;
            if (w_k_inc < kend_q) begin
              state_d = S_RD_COL;
            end else begin
              r_d     = w_r_inc;
              state_d = w_more_rows ? S_RD_PN : S_DONE;
            end
          end
        end
      end

      S_DONE: begin
        busy_d = 1'b0;
        if (!start_i) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  bsr_desc_skid #(
    .DATA_W ($bits(desc_t))
  ) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (w_push),
    .in_ready_o  (w_skid_ready),
    .in_data_i   (w_desc),
    .out_valid_o (desc_valid_o),
    .out_ready_i (desc_ready_i),
    .out_data_o  (w_out)
  );

  assign desc_row_o      = w_out.row;
  assign desc_col_o      = w_out.col;
  assign desc_blk_o      = w_out.blk;
  assign desc_wgt_base_o = w_out.wgt_base;
  assign desc_last_o     = w_out.last;

  assign busy_o  = busy_q;
  assign done_o  = (state_q == S_DONE);
  assign error_o = error_q;

endmodule
`default_nettype wire
